// File: rtl/channel_readout_sequencer_pkg.sv
// Shared definitions for the channel readout sequencer: FSM state bits,
// default channel count, and event/report word field positions.
package channel_readout_sequencer_pkg;

  localparam int NCHAN_DEF = 5;

  // One-hot state bit indices
  localparam int ST_W          = 6;
  localparam int IDLE_B        = 0;
  localparam int SELECT_B      = 1;
  localparam int REQUEST_B     = 2;
  localparam int WAIT_ACK_B    = 3;
  localparam int REPORT_HDR_B  = 4;
  localparam int REPORT_STAT_B = 5;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE        = 6'b000001 << IDLE_B,
    ST_SELECT      = 6'b000001 << SELECT_B,
    ST_REQUEST     = 6'b000001 << REQUEST_B,
    ST_WAIT_ACK    = 6'b000001 << WAIT_ACK_B,
    ST_REPORT_HDR  = 6'b000001 << REPORT_HDR_B,
    ST_REPORT_STAT = 6'b000001 << REPORT_STAT_B
  } state_t;

  // Event word fields
  localparam int EVT_TTYPE_HI = 28;
  localparam int EVT_TTYPE_LO = 24;
  localparam int EVT_TNUM_HI  = 23;
  localparam int EVT_TNUM_LO  = 0;
  localparam int HDR_KEEP_W   = 29;

  // Report status word fields
  localparam int REP_MASK_W   = 5;
  localparam int REP_DONE_LSB = 0;
  localparam int REP_TO_LSB   = 5;

  // Keep only trigger type and trigger number of an event word
  function automatic logic [HDR_KEEP_W-1:0] evt_fields(input logic [31:0] evt);
    return {evt[EVT_TTYPE_HI:EVT_TTYPE_LO], evt[EVT_TNUM_HI:EVT_TNUM_LO]};
  endfunction

  // Header report word: latched fields with the top bits zeroed
  function automatic logic [31:0] hdr_word(input logic [HDR_KEEP_W-1:0] f);
    return {3'b000, f};
  endfunction

  // Status report word: timeout mask above done mask
  function automatic logic [31:0] stat_word(input logic [REP_MASK_W-1:0] to_m,
                                            input logic [REP_MASK_W-1:0] done_m);
    logic [31:0] w;
    w = 32'd0;
    w[REP_TO_LSB +: REP_MASK_W]   = to_m;
    w[REP_DONE_LSB +: REP_MASK_W] = done_m;
    return w;
  endfunction

endpackage

// File: rtl/channel_readout_sequencer_if.sv
// Bus bundle of the readout sequencer: event FIFO pop side, per-channel
// request/ack lines and the report stream to the trigger processor.
interface channel_readout_sequencer_if
  import channel_readout_sequencer_pkg::*;
#(
  parameter int NCHAN = NCHAN_DEF
);
  logic             evt_valid;
  logic [31:0]      evt_data;
  logic             evt_ready;
  logic [NCHAN-1:0] chan_rd_req;
  logic [NCHAN-1:0] chan_rd_ack;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready;

  modport master (
    input  evt_valid, evt_data, chan_rd_ack, out_ready,
    output evt_ready, chan_rd_req, out_valid, out_data
  );

  modport slave (
    output evt_valid, evt_data, chan_rd_ack, out_ready,
    input  evt_ready, chan_rd_req, out_valid, out_data
  );
endinterface

// File: rtl/channel_readout_sequencer_lowest_bit_select.sv
// Combinational priority picker: index of the lowest set bit of a vector.
module lowest_bit_select #(
  parameter int NCHAN = 5,
  parameter int IDXW  = 3
) (
  input  logic [NCHAN-1:0] vec_i,
  output logic [IDXW-1:0]  idx_o,
  output logic             found_o
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      idx_o   = vec_i[i] ? IDXW'(i) : idx_o;
      found_o = found_o | vec_i[i];
    end
  end

endmodule

// File: rtl/channel_readout_sequencer.sv
// Channel readout sequencer: pops an event, requests a readout from each
// enabled channel in ascending order, waits for each ack (with optional
// timeout), then sends a header word and a status word downstream.
module channel_readout_sequencer
  import channel_readout_sequencer_pkg::*;
#(
  parameter int NCHAN = NCHAN_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NCHAN-1:0]            chan_en,
  input  logic [31:0]                 timeout_cycles,
  channel_readout_sequencer_if.master bus,
  output logic [ST_W-1:0]             state,
  output logic                        timeout_err,
  output logic [31:0]                 evt_count
);
  localparam int IDXW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  state_t                  state_q, state_d;
  logic [HDR_KEEP_W-1:0]   evt_q, evt_d;
  logic [NCHAN-1:0]        pending_q, pending_d;
  logic [NCHAN-1:0]        done_q, done_d;
  logic [NCHAN-1:0]        to_q, to_d;
  logic [NCHAN-1:0]        req_q, req_d;
  logic [IDXW-1:0]         cur_q, cur_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [31:0]             out_data_q, out_data_d;
  logic [31:0]             evt_count_q, evt_count_d;
  logic                    out_valid_q, out_valid_d;
  logic                    timeout_err_q, timeout_err_d;

  logic [IDXW-1:0]               sel_idx_s;
  logic                          sel_found_s;
  logic                          ack_s;
  logic                          expire_s;
  logic [NCHAN+REP_MASK_W-1:0]   done_ext_s, to_ext_s;
  logic [REP_MASK_W-1:0]         done_rep_s, to_rep_s;

  lowest_bit_select #(.NCHAN(NCHAN), .IDXW(IDXW)) u_sel (
    .vec_i   (pending_q),
    .idx_o   (sel_idx_s),
    .found_o (sel_found_s)
  );

  // Fit the channel masks into the fixed-width report fields
  always_comb begin
    done_ext_s = {{REP_MASK_W{1'b0}}, done_q};
    to_ext_s   = {{REP_MASK_W{1'b0}}, to_q};
    done_rep_s = done_ext_s[REP_MASK_W-1:0];
    to_rep_s   = to_ext_s[REP_MASK_W-1:0];
  end

  // Ack and timeout detection for the channel currently being served
  always_comb begin
    ack_s    = bus.chan_rd_ack[cur_q];
    expire_s = (timeout_cycles != 32'd0) && (cnt_q == (timeout_cycles - 32'd1));
  end

  // Next-state and datapath updates; everything holds unless a state acts
  always_comb begin
    state_d       = state_q;
    evt_d         = evt_q;
    pending_d     = pending_q;
    done_d        = done_q;
    to_d          = to_q;
    req_d         = '0;
    cur_d         = cur_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    timeout_err_d = timeout_err_q;
    evt_count_d   = evt_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.evt_valid) begin
          evt_d     = evt_fields(bus.evt_data);
          pending_d = chan_en;
          done_d    = '0;
          to_d      = '0;
          if (chan_en == '0) begin
            state_d     = ST_REPORT_HDR;
            out_valid_d = 1'b1;
            out_data_d  = hdr_word(evt_fields(bus.evt_data));
          end else begin
            state_d = ST_SELECT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SELECT: begin
        if (sel_found_s) begin
          cur_d            = sel_idx_s;
          req_d[sel_idx_s] = 1'b1;
          state_d          = ST_REQUEST;
        end else begin
          state_d     = ST_REPORT_HDR;
          out_valid_d = 1'b1;
          out_data_d  = hdr_word(evt_q);
        end
      end

      ST_REQUEST: begin
        cnt_d   = 32'd0;
        state_d = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        // An ack in the same cycle as the timeout takes priority
        if (ack_s) begin
          done_d[cur_q]    = 1'b1;
          pending_d[cur_q] = 1'b0;
        end else if (expire_s) begin
          to_d[cur_q]      = 1'b1;
          pending_d[cur_q] = 1'b0;
          timeout_err_d    = 1'b1;
        end else begin
          cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : (cnt_q + 32'd1);
        end

        if (ack_s || expire_s) begin
          if (pending_d != '0) begin
            state_d = ST_SELECT;
          end else begin
            state_d     = ST_REPORT_HDR;
            out_valid_d = 1'b1;
            out_data_d  = hdr_word(evt_q);
          end
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end

      ST_REPORT_HDR: begin
        if (bus.out_ready) begin
          state_d    = ST_REPORT_STAT;
          out_data_d = stat_word(to_rep_s, done_rep_s);
        end else begin
          state_d = ST_REPORT_HDR;
        end
      end

      ST_REPORT_STAT: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_data_d  = 32'd0;
          evt_count_d = evt_count_q + 32'd1;
        end else begin
          state_d = ST_REPORT_STAT;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_data_d  = 32'd0;
      end
    endcase
  end

  // State and datapath registers, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      evt_q         <= '0;
      pending_q     <= '0;
      done_q        <= '0;
      to_q          <= '0;
      req_q         <= '0;
      cur_q         <= '0;
      cnt_q         <= 32'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 32'd0;
      timeout_err_q <= 1'b0;
      evt_count_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      evt_q         <= evt_d;
      pending_q     <= pending_d;
      done_q        <= done_d;
      to_q          <= to_d;
      req_q         <= req_d;
      cur_q         <= cur_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      timeout_err_q <= timeout_err_d;
      evt_count_q   <= evt_count_d;
    end
  end

  assign state           = state_q;
  assign timeout_err     = timeout_err_q;
  assign evt_count       = evt_count_q;
  assign bus.evt_ready   = state_q[IDLE_B];
  assign bus.chan_rd_req = req_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;

endmodule

// File: tb/tb_channel_readout_sequencer.sv
// Self-checking bench for channel_readout_sequencer: directed scenarios plus
// randomized events checked against an event-level expectation model.
module tb_channel_readout_sequencer;

  logic        clk;
  logic        reset;
  logic [4:0]  chan_en;
  logic [31:0] timeout_cycles;
  logic [5:0]  state;
  logic        timeout_err;
  logic [31:0] evt_count;

  channel_readout_sequencer_if #(.NCHAN(5)) bus ();

  channel_readout_sequencer #(.NCHAN(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .chan_en        (chan_en),
    .timeout_cycles (timeout_cycles),
    .bus            (bus),
    .state          (state),
    .timeout_err    (timeout_err),
    .evt_count      (evt_count)
  );

  int          tests;
  int          fails;
  int          cyc;
  int          last_req_cyc;
  int          dly [5];
  int          due [5];
  int          req_q [$];
  bit          req_bad;
  logic [4:0]  en_cur;
  logic        exp_terr;
  logic [31:0] exp_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cancel_dues();
    for (int c = 0; c < 5; c++) due[c] = 0;
  endtask

  // One clock: sample after the edge, log requests, drive channel acks
  task automatic step();
    logic [4:0] ack_v;
    logic [4:0] stray;
    @(posedge clk);
    #1;
    cyc++;
    if ($countones(bus.chan_rd_req) > 1) req_bad = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (bus.chan_rd_req[c]) begin
        req_q.push_back(c);
        last_req_cyc = cyc;
      end
    end
    ack_v = 5'b00000;
    for (int c = 0; c < 5; c++) begin
      if (due[c] > 0) begin
        due[c]--;
        if (due[c] == 0) ack_v[c] = 1'b1;
      end
    end
    for (int c = 0; c < 5; c++) begin
      if (bus.chan_rd_req[c] && dly[c] != 0) due[c] = dly[c];
    end
    stray = 5'($urandom) & 5'($urandom) & ~en_cur;
    bus.chan_rd_ack = ack_v | stray;
  endtask

  // Run one event end-to-end and compare against the expected outcome
  task automatic run_event(input string tag, input logic [4:0] en, input logic [31:0] data,
                           input logic [31:0] t, input int stall_h, input int stall_s);
    logic [4:0]  exp_done;
    logic [4:0]  exp_to;
    int          exp_code;
    int          obs_code;
    int          lastc;
    int          exp_lat;
    int          n;
    bit          busy_bad;
    bit          stab_bad;
    logic [31:0] hv;

    exp_done = 5'b00000;
    exp_to   = 5'b00000;
    exp_code = 0;
    lastc    = -1;
    for (int c = 0; c < 5; c++) begin
      if (en[c]) begin
        exp_code = exp_code * 8 + c + 1;
        lastc    = c;
        if (dly[c] != 0 && (t == 0 || dly[c] <= int'(t))) exp_done[c] = 1'b1;
        else exp_to[c] = 1'b1;
      end
    end
    if (exp_to != 5'b00000) exp_terr = 1'b1;
    exp_cnt = exp_cnt + 32'd1;
    exp_lat = 0;
    if (lastc >= 0) exp_lat = exp_done[lastc] ? dly[lastc] + 1 : int'(t) + 1;

    req_q.delete();
    req_bad = 1'b0;
    check({tag, ":evt_ready_idle"}, 32'(bus.evt_ready), 32'd1);

    en_cur         = en;
    chan_en        = en;
    timeout_cycles = t;
    bus.evt_valid  = 1'b1;
    bus.evt_data   = data;
    step();
    bus.evt_valid  = 1'b0;
    bus.evt_data   = $urandom;
    chan_en        = 5'($urandom);

    busy_bad = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 1000) begin
      if (bus.evt_ready !== 1'b0) busy_bad = 1'b1;
      step();
      n++;
    end
    check({tag, ":hdr_arrives"}, 32'(n < 1000), 32'd1);
    if (n >= 1000) return;

    check({tag, ":hdr_word"}, bus.out_data, {3'b000, data[28:0]});
    if (lastc >= 0) check({tag, ":ack_latency"}, 32'(cyc - last_req_cyc), 32'(exp_lat));
    obs_code = 0;
    foreach (req_q[i]) obs_code = obs_code * 8 + req_q[i] + 1;
    check({tag, ":req_order"}, 32'(obs_code), 32'(exp_code));
    check({tag, ":req_onehot"}, 32'(req_bad), 32'd0);

    stab_bad = 1'b0;
    hv = bus.out_data;
    for (int i = 0; i < stall_h; i++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.out_data !== hv || bus.evt_ready !== 1'b0) stab_bad = 1'b1;
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, ":stat_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ":stat_word"}, bus.out_data, {22'd0, exp_to, exp_done});

    hv = bus.out_data;
    for (int i = 0; i < stall_s; i++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.out_data !== hv || bus.evt_ready !== 1'b0) stab_bad = 1'b1;
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, ":valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, ":evt_ready_back"}, 32'(bus.evt_ready), 32'd1);
    check({tag, ":evt_count"}, evt_count, exp_cnt);
    check({tag, ":timeout_err"}, 32'(timeout_err), 32'(exp_terr));
    check({tag, ":stable_while_stalled"}, 32'(stab_bad), 32'd0);
    check({tag, ":evt_ready_low_busy"}, 32'(busy_bad), 32'd0);
    cancel_dues();
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3, input int d4);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3; dly[4] = d4;
  endtask

  initial begin
    int n;
    logic [31:0] t;
    tests = 0;
    fails = 0;
    cyc = 0;
    last_req_cyc = 0;
    exp_terr = 1'b0;
    exp_cnt = 32'd0;
    en_cur = 5'b11111;
    reset = 1'b1;
    chan_en = 5'b00000;
    timeout_cycles = 32'd0;
    bus.evt_valid = 1'b0;
    bus.evt_data = 32'd0;
    bus.chan_rd_ack = 5'b00000;
    bus.out_ready = 1'b0;
    set_dly(0, 0, 0, 0, 0);
    repeat (3) step();
    reset = 1'b0;
    step();

    check("reset:state", 32'(state), 32'h1);
    check("reset:evt_ready", 32'(bus.evt_ready), 32'd1);
    check("reset:out_valid", 32'(bus.out_valid), 32'd0);
    check("reset:out_data", bus.out_data, 32'd0);
    check("reset:req", 32'(bus.chan_rd_req), 32'd0);
    check("reset:timeout_err", 32'(timeout_err), 32'd0);
    check("reset:evt_count", evt_count, 32'd0);

    set_dly(3, 3, 3, 3, 3);
    run_event("basic_10101", 5'b10101, 32'hE234_5678, 32'd0, 0, 0);
    set_dly(3, 3, 3, 3, 3);
    run_event("no_chan", 5'b00000, 32'h0300_0007, 32'd0, 0, 0);
    set_dly(4, 0, 0, 0, 0);
    run_event("ack_meets_timeout", 5'b00001, 32'h1F00_0102, 32'd4, 0, 0);
    set_dly(2, 2, 2, 2, 2);
    run_event("hdr_stall", 5'b10010, 32'h0A12_3456, 32'd0, 20, 5);
    set_dly(3, 0, 0, 0, 0);
    run_event("ch1_timeout", 5'b00011, 32'h0100_00AA, 32'd10, 0, 0);
    set_dly(5, 0, 0, 0, 0);
    run_event("ack_after_timeout", 5'b00001, 32'h0000_0001, 32'd4, 1, 1);

    for (int e = 0; e < 25; e++) begin
      t = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
      for (int c = 0; c < 5; c++) begin
        dly[c] = $urandom_range(1, 10);
        if (t != 32'd0 && $urandom_range(0, 3) == 0) dly[c] = 0;
      end
      run_event("random", 5'($urandom), $urandom, t,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset in the middle of a channel wait, followed by a stray ack
    set_dly(0, 0, 0, 0, 0);
    en_cur = 5'b00100;
    chan_en = 5'b00100;
    timeout_cycles = 32'd0;
    bus.evt_valid = 1'b1;
    bus.evt_data = 32'h0000_0055;
    step();
    bus.evt_valid = 1'b0;
    n = 0;
    while (state !== 6'b001000 && n < 20) begin
      step();
      n++;
    end
    check("midrst:reach_wait", 32'(n < 20), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cancel_dues();
    bus.chan_rd_ack = 5'b11111;
    step();
    check("midrst:state", 32'(state), 32'h1);
    check("midrst:out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst:out_data", bus.out_data, 32'd0);
    check("midrst:req", 32'(bus.chan_rd_req), 32'd0);
    check("midrst:timeout_err", 32'(timeout_err), 32'd0);
    check("midrst:evt_count", evt_count, 32'd0);
    repeat (3) step();
    check("midrst:state_later", 32'(state), 32'h1);
    check("midrst:evt_count_later", evt_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/channel_readout_sequencer.md
CHANNEL_READOUT_SEQUENCER -- requirements
Module: channel_readout_sequencer

Interface
REQ-001 Parameter NCHAN, default 5: number of Channel FPGAs sequenced.
REQ-002 clk  input  1  40 MHz TTC clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 chan_en  input  NCHAN  channels to read out for each event.
REQ-005 timeout_cycles  input  32  per-channel ack timeout in clk cycles; 0 disables the timeout.
REQ-006 evt_valid  input  1  Acquisition Event FIFO (first-word fall-through) word available.
REQ-007 evt_data  input  32  event word: [28:24] trigger type, [23:0] trigger number.
REQ-008 evt_ready  output  1  pop strobe to the Acquisition Event FIFO.
REQ-009 chan_rd_req  output  NCHAN  one-cycle readout request pulse, one bit per channel.
REQ-010 chan_rd_ack  input  NCHAN  per-channel readout-complete pulse.
REQ-011 out_valid  output  1  report word valid to the trigger processor.
REQ-012 out_data  output  32  report word.
REQ-013 out_ready  input  1  trigger processor accepts the report word.
REQ-014 state  output  6  one-hot FSM state.
REQ-015 timeout_err  output  1  sticky flag: any channel has ever timed out.
REQ-016 evt_count  output  32  count of completed events.

Function
REQ-017 The FSM SHALL use one-hot states IDLE, SELECT, REQUEST, WAIT_ACK, REPORT_HDR and REPORT_STAT.
REQ-018 evt_ready SHALL equal state[IDLE]; a pop occurs on any cycle where evt_valid and evt_ready are both high.
REQ-019 On a pop, the block SHALL latch evt_data, load pending = chan_en, clear done_mask and to_mask, and go to SELECT; if chan_en == 0, it SHALL go to REPORT_HDR instead.
REQ-020 SELECT SHALL choose cur_chan = lowest-index set bit of pending, then go to REQUEST.
REQ-021 REQUEST SHALL assert chan_rd_req[cur_chan] for exactly one cycle, clear the timeout counter, and go to WAIT_ACK.
REQ-022 In WAIT_ACK, chan_rd_ack[cur_chan] SHALL set done_mask[cur_chan] and clear pending[cur_chan].
REQ-023 In WAIT_ACK, when timeout_cycles != 0 and the counter reaches timeout_cycles-1 with no ack, the block SHALL set to_mask[cur_chan] and timeout_err, and clear pending[cur_chan].
REQ-024 If an ack and a timeout occur in the same cycle, the ack SHALL win.
REQ-025 After an ack or a timeout, the FSM SHALL go to SELECT if pending is nonzero after the update, otherwise to REPORT_HDR.
REQ-026 Acks arriving on channels other than cur_chan, or in any state other than WAIT_ACK, SHALL be ignored.
REQ-027 REPORT_HDR SHALL drive out_valid=1 and out_data = {3'd0, latched [28:0]}; the FSM SHALL go to REPORT_STAT on the cycle out_ready is high.
REQ-028 REPORT_STAT SHALL drive out_data = {22'd0, to_mask[4:0], done_mask[4:0]}; on out_ready it SHALL increment evt_count (wrapping 2^32-1 -> 0) and go to IDLE.
REQ-029 out_valid and out_data SHALL be registered and held stable until accepted.
REQ-030 chan_en SHALL be sampled only at the pop; later changes SHALL NOT affect the event in progress.
REQ-031 The timeout counter SHALL be 32 bits and saturating, so it never wraps.

Reset
REQ-032 On reset, the block SHALL go to IDLE and clear chan_rd_req, out_valid, out_data, timeout_err, evt_count and all masks, including when reset is asserted mid-event.
REQ-033 No ack arriving after reset SHALL alter any output.

Structure
REQ-034 A shared package SHALL hold the state bit indices, NCHAN, and the event and report field positions.
REQ-035 The lowest-set-bit selection SHALL be a sub-module named lowest_bit_select (combinational, NCHAN wide).

Verification
REQ-036 chan_en=5'b10101, acks 3 cycles after each req -> reqs on channels 0, 2, 4 in order; reports 0x0XXXXXXX then 0x00000015; evt_count=1.
REQ-037 timeout_cycles=10, channel 1 never acks, chan_en=5'b00011 -> ch1 req held 10 cycles then abandoned; stat word 0x00000041; timeout_err=1.
REQ-038 chan_en=0, event 0x03000007 -> no reqs; reports 0x03000007 then 0x00000000.
REQ-039 Ack and timeout in the same cycle (timeout_cycles=4, ack at cycle 4) -> done bit set, to bit clear, timeout_err=0.
REQ-040 out_ready held low for 20 cycles in REPORT_HDR -> out_valid and out_data stable; evt_ready stays low until both words are accepted.
REQ-041 Reset asserted in WAIT_ACK, then a stray ack -> state=IDLE, all outputs zero, evt_count unchanged at 0.
